pipe_ctrl: RTL and testbench

Parametrised pipeline control unit for the 5-stage RISC-V core (IF, ID, EX, MEM, WB). It replaces the fixed single-cycle-memory stall logic with four functions: a registered scoreboard of in-flight destinations, load-use and RAW hazard detection, forwarding-select generation, and a data-memory wait FSM with timeout. Its stall and flush vectors drive the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Forwarding selects drive the operand muxes in front of EX.

---
 rtl/pipe_pkg.sv | 54 +++++
 rtl/pipe_hazard_cmp.sv | 36 +++
 rtl/pipe_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline control unit: stage indices,
// stall/flush bit positions, forwarding encodings, wait-FSM states and the
// scoreboard entry layout.
package pipe_pkg;

  // Pipeline stage indices
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;
  localparam int N_STG   = 5;

  // Bit positions in stall/flush: each bit names the register it controls
  localparam int B_PC    = 0;
  localparam int B_IFID  = 1;
  localparam int B_IDEX  = 2;
  localparam int B_EXMEM = 3;
  localparam int B_MEMWB = 4;

  // Stall/flush patterns for each control situation
  localparam logic [N_STG-1:0] STALL_MEM = 5'b01111;  // hold everything up to EX/MEM
  localparam logic [N_STG-1:0] FLUSH_MEM = 5'b10000;  // bubble into MEM/WB
  localparam logic [N_STG-1:0] STALL_HAZ = 5'b00011;  // hold PC and IF/ID
  localparam logic [N_STG-1:0] FLUSH_HAZ = 5'b00100;  // bubble into ID/EX
  localparam logic [N_STG-1:0] FLUSH_BR  = 5'b00010;  // squash the wrong-path fetch

  // Operand source selects in front of EX
  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  // Data-memory wait FSM
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_TOUT = 2'd2
  } mem_state_t;

  // Wait counter width covers the largest allowed timeout (255)
  localparam int WAIT_CNT_W = 8;

  // Scoreboard entry; rd is stored zero-extended so the layout is fixed
  // regardless of the register address width (up to 8 bits).
  localparam int RD_MAX_W = 8;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                wreg;
    logic                load;
  } sb_entry_t;

endpackage

// File: rtl/pipe_hazard_cmp.sv
// Compares one ID source register against the EX and MEM scoreboard entries.
// A match requires a live read of a non-zero register by a valid ID
// instruction and a valid, register-writing producer with the same rd.
module pipe_hazard_cmp
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   rs,
  input  logic                re,
  input  logic                ex_valid,
  input  logic [RD_MAX_W-1:0] ex_rd,
  input  logic                ex_wreg,
  input  logic                ex_ld,
  input  logic                mem_valid,
  input  logic [RD_MAX_W-1:0] mem_rd,
  input  logic                mem_wreg,
  output logic                hit_ex,
  output logic                hit_mem,
  output logic                ex_load
);

  logic [RD_MAX_W-1:0] rs_ext;
  logic                src_live;

  assign rs_ext   = RD_MAX_W'(rs);
  // x0 never creates a dependency; rd == rs makes this the rd != 0 test too
  assign src_live = id_valid & re & (rs_ext != '0);

  assign hit_ex  = src_live & ex_valid  & ex_wreg  & (ex_rd  == rs_ext);
  assign hit_mem = src_live & mem_valid & mem_wreg & (mem_rd == rs_ext);
  // Load-use: the EX producer is a load whose data is not yet available
  assign ex_load = hit_ex & ex_ld;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage core: scoreboard of in-flight
// destinations, RAW/load-use hazard detection, forwarding selects and a
// data-memory wait FSM with forced release on timeout.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int FWD_EN      = 1,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs1_re_i,
  input  logic              id_rs2_re_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_wreg_i,
  input  logic              id_load_i,
  input  logic              id_branch_i,
  input  logic              mem_req_i,
  input  logic              mem_ack_i,
  output logic [4:0]        stall_o,
  output logic [4:0]        flush_o,
  output logic [1:0]        fwd1_sel_o,
  output logic [1:0]        fwd2_sel_o,
  output logic              mem_timeout_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(MEM_TIMEOUT);

  // Scoreboard: EX entry as a struct, MEM entry keeps only what matching needs
  sb_entry_t           ex_q, ex_d;
  logic                mem_valid_q;
  logic [RD_MAX_W-1:0] mem_rd_q;
  logic                mem_wreg_q;

  mem_state_t            state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  mem_wait;

  logic h1_ex, h1_mem, h1_ld;
  logic h2_ex, h2_mem, h2_ld;
  logic hazard;

  pipe_hazard_cmp #(.REG_AW(REG_AW)) u_cmp_rs1 (
    .id_valid  (id_valid_i),
    .rs        (id_rs1_i),
    .re        (id_rs1_re_i),
    .ex_valid  (ex_q.valid),
    .ex_rd     (ex_q.rd),
    .ex_wreg   (ex_q.wreg),
    .ex_ld     (ex_q.load),
    .mem_valid (mem_valid_q),
    .mem_rd    (mem_rd_q),
    .mem_wreg  (mem_wreg_q),
    .hit_ex    (h1_ex),
    .hit_mem   (h1_mem),
    .ex_load   (h1_ld)
  );

  pipe_hazard_cmp #(.REG_AW(REG_AW)) u_cmp_rs2 (
    .id_valid  (id_valid_i),
    .rs        (id_rs2_i),
    .re        (id_rs2_re_i),
    .ex_valid  (ex_q.valid),
    .ex_rd     (ex_q.rd),
    .ex_wreg   (ex_q.wreg),
    .ex_ld     (ex_q.load),
    .mem_valid (mem_valid_q),
    .mem_rd    (mem_rd_q),
    .mem_wreg  (mem_wreg_q),
    .hit_ex    (h2_ex),
    .hit_mem   (h2_mem),
    .ex_load   (h2_ld)
  );

  // With forwarding only a load in EX forces a stall; without it any
  // in-flight producer of a source register does.
  assign hazard = (FWD_EN != 0) ? (h1_ld | h2_ld)
                                : (h1_ex | h1_mem | h2_ex | h2_mem);

  // Wait FSM next state; the count holds wait cycles completed so far
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_wait   = 1'b0;
    // Outputs must read idle while reset is held, even with a request pending
    if (rst) begin
      mem_wait = mem_req_i & ~mem_ack_i & (state_q != ST_TOUT);
      unique case (state_q)
        ST_IDLE: begin
          if (mem_wait) begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (!mem_wait) begin
            // Acked, or the request was withdrawn
            state_d = ST_IDLE;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
            // This cycle is the last allowed wait cycle: release next cycle
            if (wait_cnt_d == TIMEOUT_CNT) state_d = ST_TOUT;
          end
        end
        ST_TOUT: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Wait FSM state and counter registers
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Control outputs by priority: memory wait, data hazard, branch
  always_comb begin
    stall_o       = '0;
    flush_o       = '0;
    fwd1_sel_o    = FWD_RF;
    fwd2_sel_o    = FWD_RF;
    mem_timeout_o = 1'b0;
    if (rst) begin
      mem_timeout_o = (state_q == ST_TOUT);
      if (mem_wait) begin
        // ID is held, so a branch there is simply taken later
        stall_o = STALL_MEM;
        flush_o = FLUSH_MEM;
      end else if (hazard) begin
        // Branch operands are stale this cycle; it re-resolves after the stall
        stall_o = STALL_HAZ;
        flush_o = FLUSH_HAZ;
      end else begin
        if (id_branch_i && id_valid_i) flush_o = FLUSH_BR;
        if (FWD_EN != 0) begin
          fwd1_sel_o = h1_ex ? FWD_EXMEM : (h1_mem ? FWD_MEMWB : FWD_RF);
          fwd2_sel_o = h2_ex ? FWD_EXMEM : (h2_mem ? FWD_MEMWB : FWD_RF);
        end
      end
    end
  end

  // ID fields entering EX; a bubble inserted into ID/EX is recorded as invalid
  always_comb begin
    ex_d.valid = id_valid_i & ~flush_o[B_IDEX];
    ex_d.rd    = RD_MAX_W'(id_rd_i);
    ex_d.wreg  = id_wreg_i;
    ex_d.load  = id_load_i;
  end

  // Scoreboard shift, following the ID/EX and EX/MEM hold controls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q        <= '0;
      mem_valid_q <= 1'b0;
      mem_rd_q    <= '0;
      mem_wreg_q  <= 1'b0;
    end else begin
      if (!stall_o[B_IDEX]) ex_q <= ex_d;
      if (!stall_o[B_EXMEM]) begin
        mem_valid_q <= ex_q.valid;
        mem_rd_q    <= ex_q.rd;
        mem_wreg_q  <= ex_q.wreg;
      end
    end
  end

  // Saturating count of cycles with the PC held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o <= '0;
    end else if (stall_o[B_PC] && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a vector table for the forwarding/hazard
// stream plus hand-written sequences for memory wait, timeout, branch
// deferral, mid-wait reset, no-forwarding stalls and counter saturation.
module tb_pipe_ctrl;

  localparam int AW = 5;
  localparam int CW = 4;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          id_valid_i = 1'b0;
  logic [AW-1:0] id_rs1_i = '0;
  logic [AW-1:0] id_rs2_i = '0;
  logic          id_rs1_re_i = 1'b0;
  logic          id_rs2_re_i = 1'b0;
  logic [AW-1:0] id_rd_i = '0;
  logic          id_wreg_i = 1'b0;
  logic          id_load_i = 1'b0;
  logic          id_branch_i = 1'b0;
  logic          mem_req_i = 1'b0;
  logic          mem_ack_i = 1'b0;

  logic [4:0]    stall_o, flush_o;
  logic [1:0]    fwd1_sel_o, fwd2_sel_o;
  logic          mem_timeout_o;
  logic [CW-1:0] stall_cnt_o;

  logic [4:0]    nf_stall, nf_flush;
  logic [1:0]    nf_fwd1, nf_fwd2;
  logic          nf_tout;
  logic [CW-1:0] nf_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.REG_AW(AW), .FWD_EN(1), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk (clk), .rst (rst),
    .id_valid_i (id_valid_i), .id_rs1_i (id_rs1_i), .id_rs2_i (id_rs2_i),
    .id_rs1_re_i (id_rs1_re_i), .id_rs2_re_i (id_rs2_re_i),
    .id_rd_i (id_rd_i), .id_wreg_i (id_wreg_i), .id_load_i (id_load_i),
    .id_branch_i (id_branch_i), .mem_req_i (mem_req_i), .mem_ack_i (mem_ack_i),
    .stall_o (stall_o), .flush_o (flush_o),
    .fwd1_sel_o (fwd1_sel_o), .fwd2_sel_o (fwd2_sel_o),
    .mem_timeout_o (mem_timeout_o), .stall_cnt_o (stall_cnt_o)
  );

  pipe_ctrl #(.REG_AW(AW), .FWD_EN(0), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut_nf (
    .clk (clk), .rst (rst),
    .id_valid_i (id_valid_i), .id_rs1_i (id_rs1_i), .id_rs2_i (id_rs2_i),
    .id_rs1_re_i (id_rs1_re_i), .id_rs2_re_i (id_rs2_re_i),
    .id_rd_i (id_rd_i), .id_wreg_i (id_wreg_i), .id_load_i (id_load_i),
    .id_branch_i (id_branch_i), .mem_req_i (mem_req_i), .mem_ack_i (mem_ack_i),
    .stall_o (nf_stall), .flush_o (nf_flush),
    .fwd1_sel_o (nf_fwd1), .fwd2_sel_o (nf_fwd2),
    .mem_timeout_o (nf_tout), .stall_cnt_o (nf_cnt)
  );

  typedef struct {
    logic          valid;
    logic [AW-1:0] rs1, rs2;
    logic          re1, re2;
    logic [AW-1:0] rd;
    logic          wreg, load, branch;
    logic [4:0]    stall, flush;
    logic [1:0]    fwd1, fwd2;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic v, input int rs1, input int rs2,
                              input logic re1, input logic re2, input int rd,
                              input logic w, input logic ld, input logic br,
                              input logic [4:0] s, input logic [4:0] f,
                              input int f1, input int f2, input int cnt);
    vec_t r;
    r.valid = v;  r.rs1 = AW'(rs1); r.rs2 = AW'(rs2);
    r.re1 = re1;  r.re2 = re2;      r.rd = AW'(rd);
    r.wreg = w;   r.load = ld;      r.branch = br;
    r.stall = s;  r.flush = f;
    r.fwd1 = 2'(f1); r.fwd2 = 2'(f2); r.cnt = CW'(cnt);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Compares {stall, flush, fwd1, fwd2, timeout} of the forwarding instance
  task automatic check_out(input string name, input logic [4:0] s, input logic [4:0] f,
                           input logic [1:0] f1, input logic [1:0] f2, input logic t);
    check(name, 32'({stall_o, flush_o, fwd1_sel_o, fwd2_sel_o, mem_timeout_o}),
          32'({s, f, f1, f2, t}));
  endtask

  task automatic set_id(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic re1, input logic re2, input logic [AW-1:0] rd,
                        input logic w, input logic ld, input logic br);
    id_valid_i = v;    id_rs1_i = rs1;    id_rs2_i = rs2;
    id_rs1_re_i = re1; id_rs2_re_i = re2; id_rd_i = rd;
    id_wreg_i = w;     id_load_i = ld;    id_branch_i = br;
  endtask

  task automatic set_idle();
    set_id(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Inputs change 1 unit after the rising edge, outputs are sampled 3 later
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //              v rs1 rs2 re1 re2 rd w ld br  stall     flush    f1 f2 cnt
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0);
    vecs[1]  = mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 5'b00000, 5'b00000, 0, 0, 0);
    vecs[2]  = mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 5'b00000, 5'b00000, 1, 0, 0);
    vecs[3]  = mk(1, 6, 5, 1, 1, 0, 1, 0, 0, 5'b00000, 5'b00000, 1, 2, 0);
    vecs[4]  = mk(1, 0, 6, 1, 1, 9, 0, 0, 0, 5'b00000, 5'b00000, 0, 2, 0);
    vecs[5]  = mk(1, 9, 0, 1, 0, 7, 1, 1, 0, 5'b00000, 5'b00000, 0, 0, 0);
    vecs[6]  = mk(1, 1, 7, 1, 1, 8, 1, 0, 0, 5'b00011, 5'b00100, 0, 0, 0);
    vecs[7]  = mk(1, 1, 7, 1, 1, 8, 1, 0, 0, 5'b00000, 5'b00000, 0, 2, 1);
    vecs[8]  = mk(1, 8, 0, 1, 0, 0, 0, 0, 1, 5'b00000, 5'b00010, 1, 0, 1);
    vecs[9]  = mk(1, 8, 0, 1, 0, 3, 1, 1, 0, 5'b00000, 5'b00000, 2, 0, 1);
    vecs[10] = mk(1, 3, 0, 1, 0, 0, 0, 0, 1, 5'b00011, 5'b00100, 0, 0, 1);
    vecs[11] = mk(1, 3, 0, 1, 0, 0, 0, 0, 1, 5'b00000, 5'b00010, 2, 0, 2);
    vecs[12] = mk(0, 3, 0, 1, 0, 0, 0, 0, 1, 5'b00000, 5'b00000, 0, 0, 2);
    vecs[13] = mk(1, 0, 0, 1, 1, 0, 1, 0, 0, 5'b00000, 5'b00000, 0, 0, 2);
    vecs[14] = mk(1, 0, 0, 1, 0, 4, 1, 0, 0, 5'b00000, 5'b00000, 0, 0, 2);
    vecs[15] = mk(1, 4, 4, 0, 1, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 1, 2);

    // Reset with a pending request and a branch: everything must read idle
    set_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b1);
    mem_req_i = 1'b1;
    #12;
    check_out("reset_outs", 5'b00000, 5'b00000, 2'd0, 2'd0, 1'b0);
    check("reset_cnt", 32'(stall_cnt_o), 32'd0);
    set_idle();
    mem_req_i = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;

    // Forwarding / load-use / branch stream
    for (int i = 0; i < 16; i++) begin
      next_cycle();
      set_id(vecs[i].valid, vecs[i].rs1, vecs[i].rs2, vecs[i].re1, vecs[i].re2,
             vecs[i].rd, vecs[i].wreg, vecs[i].load, vecs[i].branch);
      settle();
      check($sformatf("vec%0d", i),
            32'({stall_o, flush_o, fwd1_sel_o, fwd2_sel_o, mem_timeout_o, stall_cnt_o}),
            32'({vecs[i].stall, vecs[i].flush, vecs[i].fwd1, vecs[i].fwd2, 1'b0, vecs[i].cnt}));
    end

    // Memory wait acked on the fourth cycle: exactly three stall cycles
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      set_idle();
      mem_req_i = 1'b1;
      mem_ack_i = 1'b0;
      settle();
      check_out($sformatf("memwait%0d", k), 5'b01111, 5'b10000, 2'd0, 2'd0, 1'b0);
    end
    next_cycle();
    mem_ack_i = 1'b1;
    settle();
    check_out("memack", 5'b00000, 5'b00000, 2'd0, 2'd0, 1'b0);
    next_cycle();
    mem_req_i = 1'b0;
    mem_ack_i = 1'b0;
    settle();
    check("cnt_after_wait", 32'(stall_cnt_o), 32'd5);

    // Branch arriving during a wait is deferred to the first unstalled cycle
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      set_id(1'b1, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      mem_req_i = 1'b1;
      settle();
      check_out($sformatf("brwait%0d", k), 5'b01111, 5'b10000, 2'd0, 2'd0, 1'b0);
    end
    next_cycle();
    mem_ack_i = 1'b1;
    settle();
    check_out("brrelease", 5'b00000, 5'b00010, 2'd0, 2'd0, 1'b0);
    next_cycle();
    set_idle();
    mem_req_i = 1'b0;
    mem_ack_i = 1'b0;
    settle();
    check_out("brdone", 5'b00000, 5'b00000, 2'd0, 2'd0, 1'b0);

    // No ack: MEM_TIMEOUT stall cycles, then a one-cycle forced release
    for (int k = 0; k < TO; k++) begin
      next_cycle();
      mem_req_i = 1'b1;
      settle();
      check_out($sformatf("toutwait%0d", k), 5'b01111, 5'b10000, 2'd0, 2'd0, 1'b0);
    end
    next_cycle();
    settle();
    check_out("tout_pulse", 5'b00000, 5'b00000, 2'd0, 2'd0, 1'b1);
    next_cycle();
    mem_req_i = 1'b0;
    settle();
    check_out("tout_end", 5'b00000, 5'b00000, 2'd0, 2'd0, 1'b0);
    check("cnt_after_tout", 32'(stall_cnt_o), 32'd11);

    // Reset in the middle of a wait abandons it; a new wait times out fresh
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      mem_req_i = 1'b1;
      settle();
      check_out($sformatf("prerst%0d", k), 5'b01111, 5'b10000, 2'd0, 2'd0, 1'b0);
    end
    rst = 1'b0;
    #1;
    check_out("rst_mid", 5'b00000, 5'b00000, 2'd0, 2'd0, 1'b0);
    check("rst_mid_cnt", 32'(stall_cnt_o), 32'd0);
    next_cycle();
    rst = 1'b1;
    mem_req_i = 1'b0;
    settle();
    check_out("rst_release", 5'b00000, 5'b00000, 2'd0, 2'd0, 1'b0);
    for (int k = 0; k < TO; k++) begin
      next_cycle();
      mem_req_i = 1'b1;
      settle();
      check_out($sformatf("postrst%0d", k), 5'b01111, 5'b10000, 2'd0, 2'd0, 1'b0);
    end
    next_cycle();
    settle();
    check_out("postrst_tout", 5'b00000, 5'b00000, 2'd0, 2'd0, 1'b1);
    next_cycle();
    mem_req_i = 1'b0;
    settle();
    check("postrst_cnt", 32'(stall_cnt_o), 32'd4);

    // Without forwarding an ALU RAW stalls until the producer leaves MEM
    next_cycle();
    set_id(1'b1, '0, '0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    settle();
    check("nf_add", 32'(nf_stall), 32'd0);
    next_cycle();
    set_id(1'b1, 5'd3, '0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
    settle();
    check_out("fwd_raw", 5'b00000, 5'b00000, 2'd1, 2'd0, 1'b0);
    check("nf_raw1", 32'({nf_stall, nf_flush, nf_fwd1}), 32'({5'b00011, 5'b00100, 2'd0}));
    next_cycle();
    settle();
    check("nf_raw2", 32'({nf_stall, nf_flush, nf_fwd1}), 32'({5'b00011, 5'b00100, 2'd0}));
    next_cycle();
    settle();
    check("nf_raw3", 32'({nf_stall, nf_flush, nf_fwd1}), 32'({5'b00000, 5'b00000, 2'd0}));
    next_cycle();
    set_id(1'b1, '0, '0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    settle();
    next_cycle();
    set_id(1'b1, 5'd0, '0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    settle();
    check("nf_x0", 32'({nf_stall, nf_fwd1}), 32'({5'b00000, 2'd0}));
    check("fwd_cnt", 32'(stall_cnt_o), 32'd4);

    // Stall counter saturates at all-ones instead of wrapping
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      set_idle();
      mem_req_i = 1'b1;
    end
    next_cycle();
    mem_req_i = 1'b0;
    settle();
    check("cnt_saturate", 32'(stall_cnt_o), 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
